// File: rtl/ttl74x201_march_tester.sv
// ----------------------------------------------------------------------------
// ttl74x201_march_tester
//
// March C- initiator for a TTL74x201-style static RAM (2^ADDR_WIDTH words,
// registered inverted read data). The tester drives the RAM select, R_W,
// address and data pins directly. It runs the six March C- elements over the
// whole address space and reports the first mismatch.
//
// Every tester cycle is one of three kinds:
//   WR  : S_n=0, R_W=0, D=background  (RAM writes at the closing edge)
//   RD  : S_n=0, R_W=1                (RAM registers ~data at the closing edge)
//   CHK : S_n=1, R_W=1                (~Q_n compared at the closing edge)
// A read is always RD immediately followed by CHK. This covers the one cycle
// of RAM read latency.
//
// Elements: M0 up(w0), M1 up(r0,w1), M2 up(r1,w0),
//           M3 down(r0,w1), M4 down(r1,w0), M5 down(r0).
// A clean run keeps busy high for 15 * 2^ADDR_WIDTH cycles.
//
// Ports
//   clk        system clock, shared with the RAM under test
//   rst_n      asynchronous active-low reset
//   start      one-cycle request to begin a test (honoured in IDLE/DONE only)
//   busy       high while the test is running
//   done       high in DONE until the next accepted start or reset
//   fail       valid with done; 1 = mismatch detected
//   fail_elem  March element (0-5) of the first mismatch
//   fail_addr  address of the first mismatch
//   fail_data  observed true-polarity data at the mismatch
//   R_W        to RAM: 1 = read, 0 = write
//   S_n        to RAM: active-low select
//   A          to RAM: address
//   D          to RAM: data in
//   Q_n        from RAM: inverted read data, valid the cycle after RD
// ----------------------------------------------------------------------------
module ttl74x201_march_tester #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [2:0]            fail_elem,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_data,
    output logic                  R_W,
    output logic                  S_n,
    output logic [ADDR_WIDTH-1:0] A,
    output logic [DATA_WIDTH-1:0] D,
    input  logic [DATA_WIDTH-1:0] Q_n
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_RD   = 3'd2,
        ST_CHK  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX  = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] DATA_ONES = {DATA_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};
    localparam logic [2:0]            ELEM_LAST = 3'd5;

    // Background written by the WR of each element (M1 and M3 write ones).
    function automatic logic [DATA_WIDTH-1:0] write_bg(input logic [2:0] elem);
        logic [DATA_WIDTH-1:0] bg;
        case (elem)
            3'd1, 3'd3: bg = DATA_ONES;
            default:    bg = DATA_ZERO;
        endcase
        return bg;
    endfunction

    // Background expected by the read of each element (M2 and M4 read ones).
    function automatic logic [DATA_WIDTH-1:0] read_bg(input logic [2:0] elem);
        logic [DATA_WIDTH-1:0] bg;
        case (elem)
            3'd2, 3'd4: bg = DATA_ONES;
            default:    bg = DATA_ZERO;
        endcase
        return bg;
    endfunction

    // M3, M4 and M5 walk the address space downwards.
    function automatic logic is_descending(input logic [2:0] elem);
        return (elem >= 3'd3);
    endfunction

    state_t                  state_r;
    logic [2:0]              elem_r;
    logic [ADDR_WIDTH-1:0]   addr_r;

    state_t                  step_state_s;
    logic [2:0]              step_elem_s;
    logic [ADDR_WIDTH-1:0]   step_addr_s;
    logic                    last_step_s;
    logic                    elem_end_s;

    state_t                  tgt_state_s;
    logic [2:0]              tgt_elem_s;
    logic [ADDR_WIDTH-1:0]   tgt_addr_s;

    logic                    running_s;
    logic                    launch_s;
    logic [DATA_WIDTH-1:0]   observed_s;
    logic                    mismatch_s;

    // Status decode and read-data compare for the current cycle.
    always_comb begin
        running_s  = (state_r == ST_WR) || (state_r == ST_RD) || (state_r == ST_CHK);
        launch_s   = ((state_r == ST_IDLE) || (state_r == ST_DONE)) && start;
        observed_s = ~Q_n;
        mismatch_s = (state_r == ST_CHK) && (observed_s != read_bg(elem_r));
    end

    // Next position in the March sequence, assuming no mismatch.
    always_comb begin
        step_state_s = state_r;
        step_elem_s  = elem_r;
        step_addr_s  = addr_r;
        // The last cycle for an address is its WR, except in M5 (read only).
        last_step_s  = (state_r == ST_WR) ||
                       ((state_r == ST_CHK) && (elem_r == ELEM_LAST));
        // Element end is compared against the terminal address, not a wrap.
        if (is_descending(elem_r)) begin
            elem_end_s = (addr_r == ADDR_ZERO);
        end else begin
            elem_end_s = (addr_r == ADDR_MAX);
        end

        if (state_r == ST_RD) begin
            step_state_s = ST_CHK;
        end else if (!last_step_s) begin
            // CHK inside M1..M4 is followed by the write half.
            step_state_s = ST_WR;
        end else if (!elem_end_s) begin
            if (is_descending(elem_r)) begin
                step_addr_s = addr_r - {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                step_addr_s = addr_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            end
            if (elem_r == 3'd0) begin
                step_state_s = ST_WR;
            end else begin
                step_state_s = ST_RD;
            end
        end else if (elem_r == ELEM_LAST) begin
            step_state_s = ST_DONE;
        end else begin
            // Every element after M0 opens with a read.
            step_elem_s  = elem_r + 3'd1;
            step_state_s = ST_RD;
            if (is_descending(elem_r + 3'd1)) begin
                step_addr_s = ADDR_MAX;
            end else begin
                step_addr_s = ADDR_ZERO;
            end
        end
    end

    // Target state for the next cycle: launch, stop on mismatch, or step.
    always_comb begin
        tgt_state_s = state_r;
        tgt_elem_s  = elem_r;
        tgt_addr_s  = addr_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    tgt_state_s = ST_WR;
                    tgt_elem_s  = 3'd0;
                    tgt_addr_s  = ADDR_ZERO;
                end else begin
                    tgt_state_s = state_r;
                end
            end
            ST_WR, ST_RD, ST_CHK: begin
                if (mismatch_s) begin
                    tgt_state_s = ST_DONE;
                end else begin
                    tgt_state_s = step_state_s;
                    tgt_elem_s  = step_elem_s;
                    tgt_addr_s  = step_addr_s;
                end
            end
            default: begin
                tgt_state_s = ST_IDLE;
                tgt_elem_s  = 3'd0;
                tgt_addr_s  = ADDR_ZERO;
            end
        endcase
    end

    // Sequencer state and all registered outputs, including the RAM pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            elem_r    <= 3'd0;
            addr_r    <= ADDR_ZERO;
            busy      <= 1'b0;
            done      <= 1'b0;
            fail      <= 1'b0;
            fail_elem <= 3'd0;
            fail_addr <= ADDR_ZERO;
            fail_data <= DATA_ZERO;
            R_W       <= 1'b1;
            S_n       <= 1'b1;
            A         <= ADDR_ZERO;
            D         <= DATA_ZERO;
        end else begin
            state_r <= tgt_state_s;
            elem_r  <= tgt_elem_s;
            addr_r  <= tgt_addr_s;

            busy <= (tgt_state_s == ST_WR) || (tgt_state_s == ST_RD) ||
                    (tgt_state_s == ST_CHK);
            done <= (tgt_state_s == ST_DONE);

            // RAM is selected only for WR and RD; CHK just waits for Q_n.
            S_n <= !((tgt_state_s == ST_WR) || (tgt_state_s == ST_RD));
            R_W <= (tgt_state_s != ST_WR);

            // Address and data hold their last values when not in use.
            if ((tgt_state_s == ST_WR) || (tgt_state_s == ST_RD)) begin
                A <= tgt_addr_s;
            end else begin
                A <= A;
            end
            if (tgt_state_s == ST_WR) begin
                D <= write_bg(tgt_elem_s);
            end else begin
                D <= D;
            end

            // Failure record clears on launch and captures only the first miss.
            if (launch_s) begin
                fail      <= 1'b0;
                fail_elem <= 3'd0;
                fail_addr <= ADDR_ZERO;
                fail_data <= DATA_ZERO;
            end else if (running_s && mismatch_s) begin
                fail      <= 1'b1;
                fail_elem <= elem_r;
                fail_addr <= addr_r;
                fail_data <= observed_s;
            end else begin
                fail      <= fail;
                fail_elem <= fail_elem;
                fail_addr <= fail_addr;
                fail_data <= fail_data;
            end
        end
    end

endmodule

// File: tb/tb_ttl74x201_march_tester.sv
// ----------------------------------------------------------------------------
// Scoreboard bench for ttl74x201_march_tester. Two testers are instantiated:
// an 8-bit one driving a 256x1 RAM model with injectable faults, and a 4-bit
// one driving a fault-free 16x1 RAM model. Each start pushes the expected
// result record; a per-DUT monitor pops and compares whenever done rises.
// ----------------------------------------------------------------------------
module tb_ttl74x201_march_tester;

    typedef struct {
        int cycles;
        int fail;
        int elem;
        int addr;
        int data;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    // 0 = none, 1 = cell 0x37 stuck-at-0, 2 = cell 0x37 stuck-at-1, 3 = A[7] tied low
    int   fault_mode;

    exp_t q8[$];
    exp_t q4[$];

    // ---------------- 8-bit tester + RAM model ----------------
    logic       start8, busy8, done8, fail8, rw8, s8_n;
    logic [2:0] fe8;
    logic [7:0] fa8, a8;
    logic [0:0] fd8, d8, q8_n;
    bit         mem8 [0:255];
    logic [7:0] ea8;
    logic       rv8;

    ttl74x201_march_tester #(.ADDR_WIDTH(8), .DATA_WIDTH(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .busy(busy8), .done(done8),
        .fail(fail8), .fail_elem(fe8), .fail_addr(fa8), .fail_data(fd8),
        .R_W(rw8), .S_n(s8_n), .A(a8), .D(d8), .Q_n(q8_n)
    );

    assign ea8 = (fault_mode == 3) ? {1'b0, a8[6:0]} : a8;
    assign rv8 = (ea8 == 8'h37 && fault_mode == 1) ? 1'b0 :
                 (ea8 == 8'h37 && fault_mode == 2) ? 1'b1 : mem8[ea8];

    always @(posedge clk) begin
        if (!s8_n && !rw8) mem8[ea8] <= d8[0];
        if (!s8_n && rw8)  q8_n      <= ~rv8;
    end

    // ---------------- 4-bit tester + RAM model ----------------
    logic       start4, busy4, done4, fail4, rw4, s4_n;
    logic [2:0] fe4;
    logic [3:0] fa4, a4;
    logic [0:0] fd4, d4, q4_n;
    bit         mem4 [0:15];

    ttl74x201_march_tester #(.ADDR_WIDTH(4), .DATA_WIDTH(1)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .busy(busy4), .done(done4),
        .fail(fail4), .fail_elem(fe4), .fail_addr(fa4), .fail_data(fd4),
        .R_W(rw4), .S_n(s4_n), .A(a4), .D(d4), .Q_n(q4_n)
    );

    always @(posedge clk) begin
        if (!s4_n && !rw4) mem4[a4] <= d4[0];
        if (!s4_n && rw4)  q4_n     <= ~mem4[a4];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor for the 8-bit tester: busy-cycle counting and result compare.
    initial begin
        int   bc;
        logic bprev, dprev;
        exp_t e;
        bc = 0; bprev = 1'b0; dprev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bc = 0; bprev = 1'b0; dprev = 1'b0;
            end else begin
                if (busy8 && !bprev) bc = 1;
                else if (busy8)      bc++;
                if (done8 && !dprev) begin
                    check("dut8_result_expected", q8.size() > 0, 1);
                    if (q8.size() > 0) begin
                        e = q8.pop_front();
                        check("dut8_busy_cycles", bc, e.cycles);
                        check("dut8_busy_low", busy8, 0);
                        check("dut8_s_n_idle", s8_n, 1);
                        check("dut8_fail", fail8, e.fail);
                        check("dut8_fail_elem", fe8, e.elem);
                        check("dut8_fail_addr", fa8, e.addr);
                        check("dut8_fail_data", fd8, e.data);
                    end
                end
                bprev = busy8; dprev = done8;
            end
        end
    end

    // Monitor for the 4-bit tester.
    initial begin
        int   bc;
        logic bprev, dprev;
        exp_t e;
        bc = 0; bprev = 1'b0; dprev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bc = 0; bprev = 1'b0; dprev = 1'b0;
            end else begin
                if (busy4 && !bprev) bc = 1;
                else if (busy4)      bc++;
                if (done4 && !dprev) begin
                    check("dut4_result_expected", q4.size() > 0, 1);
                    if (q4.size() > 0) begin
                        e = q4.pop_front();
                        check("dut4_busy_cycles", bc, e.cycles);
                        check("dut4_fail", fail4, e.fail);
                        check("dut4_fail_elem", fe4, e.elem);
                        check("dut4_fail_addr", fa4, e.addr);
                    end
                end
                bprev = busy4; dprev = done4;
            end
        end
    end

    task automatic pulse8();
        @(negedge clk); start8 = 1'b1;
        @(negedge clk); start8 = 1'b0;
    endtask

    task automatic pulse4();
        @(negedge clk); start4 = 1'b1;
        @(negedge clk); start4 = 1'b0;
    endtask

    task automatic wait_done8(input int max_cycles, input string name);
        int n;
        n = 0;
        while (!done8 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        if (!done8) check({name, "_timeout"}, 0, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_done4(input int max_cycles, input string name);
        int n;
        n = 0;
        while (!done4 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        if (!done4) check({name, "_timeout"}, 0, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic push8(input int c, input int f, input int el, input int ad, input int da);
        exp_t e;
        e.cycles = c; e.fail = f; e.elem = el; e.addr = ad; e.data = da;
        q8.push_back(e);
    endtask

    task automatic push4(input int c);
        exp_t e;
        e.cycles = c; e.fail = 0; e.elem = 0; e.addr = 0; e.data = 0;
        q4.push_back(e);
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        fault_mode = 0;
        rst_n = 1'b0; start8 = 1'b0; start4 = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_busy", busy8, 0);
        check("rst_done", done8, 0);
        check("rst_fail", fail8, 0);
        check("rst_fail_elem", fe8, 0);
        check("rst_fail_addr", fa8, 0);
        check("rst_fail_data", fd8, 0);
        check("rst_r_w", rw8, 1);
        check("rst_s_n", s8_n, 1);
        check("rst_a", a8, 0);
        check("rst_d", d8, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Clean 8-bit run; an extra start mid-run must be ignored.
        push8(3840, 0, 0, 0, 0);
        pulse8();
        check("first_cycle_busy", busy8, 1);
        repeat (100) @(negedge clk);
        pulse8();
        wait_done8(5000, "clean8");

        // Stuck-at-0 at 0x37: caught by M2 r1. 256 + 768 + 0x37*3 + 2 = 1191.
        fault_mode = 1;
        push8(1191, 1, 2, 8'h37, 0);
        pulse8();
        wait_done8(5000, "sa0");

        // Stuck-at-1 at 0x37: caught by M1 r0. 256 + 0x37*3 + 2 = 423.
        fault_mode = 2;
        push8(423, 1, 1, 8'h37, 1);
        pulse8();
        wait_done8(5000, "sa1");

        // A[7] tied low: 0x80 aliases 0x00, already written 1 in M1. 256 + 128*3 + 2 = 642.
        fault_mode = 3;
        push8(642, 1, 1, 8'h80, 1);
        pulse8();
        wait_done8(5000, "addr_fault");
        fault_mode = 0;

        // 4-bit tester: two clean runs, the second launched from DONE.
        push4(240);
        pulse4();
        wait_done4(1000, "clean4_a");
        push4(240);
        pulse4();
        wait_done4(1000, "clean4_b");

        // Asynchronous reset in the middle of a run.
        pulse8();
        repeat (1000) @(negedge clk);
        check("midrun_busy_before_reset", busy8, 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrun_rst_busy", busy8, 0);
        check("midrun_rst_s_n", s8_n, 1);
        check("midrun_rst_r_w", rw8, 1);
        check("midrun_rst_done", done8, 0);
        check("midrun_rst_a", a8, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("midrun_stays_idle", busy8, 0);
        check("q8_drained", q8.size(), 0);
        check("q4_drained", q4.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ttl74x201_march_tester.md
Name: ttl74x201_march_tester

Overview:
- Initiator-side companion to the TTL74x201 RAM model (256x1 bipolar static RAM with registered inverted read).
- Drives the RAM's R_W, select, address and data pins directly.
- Runs a March C- test over the full address space and reports pass/fail with fault location.
- Used as a power-on self-test for RAM-bearing TTL reconstructions and as a stimulus engine for the RAM model on the bench.

Parameters:
- ADDR_WIDTH, 8, RAM address bits; the test covers 2^ADDR_WIDTH words.
- DATA_WIDTH, 1, RAM word width. Background "0" is all-zeros; background "1" is all-ones.

Ports:
- clk  input  1  system clock, shared with the RAM under test.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a test. Sampled only in IDLE or DONE.
- busy  output  1  high while a test is running.
- done  output  1  high in DONE; held until the next accepted start or reset.
- fail  output  1  valid with done; 1 means a mismatch was detected.
- fail_elem  output  3  March element (0-5) where the first mismatch occurred.
- fail_addr  output  ADDR_WIDTH  address of the first mismatch.
- fail_data  output  DATA_WIDTH  observed (true-polarity) data at the mismatch.
- R_W  output  1  to RAM: 1 = read, 0 = write.
- S_n  output  1  to RAM: active-low select. Bench ties it to S1_n; S2_n and S3_n are held 0.
- A  output  ADDR_WIDTH  to RAM address.
- D  output  DATA_WIDTH  to RAM data in.
- Q_n  input  DATA_WIDTH  from RAM: inverted read data, valid the cycle after a read cycle.

Behaviour:
- All outputs are registered.
- Reset (asynchronous, takes effect immediately, including mid-test): busy=0, done=0, fail=0, fail_elem=0, fail_addr=0, fail_data=0, R_W=1, S_n=1, A=0, D=0. State goes to IDLE.
- Cycle types (RAM samples at the rising edge that ends each cycle):
  - WR: S_n=0, R_W=0, D=background.
  - RD: S_n=0, R_W=1.
  - CHK: S_n=1, R_W=1. Compares ~Q_n with the expected background.
- A read is always RD followed immediately by CHK. This gives one cycle of RAM read latency; no other spacing is permitted.
- March elements, with N = 2^ADDR_WIDTH:
  - M0: ascending, (w0).
  - M1: ascending, (r0, w1).
  - M2: ascending, (r1, w0).
  - M3: descending, (r0, w1).
  - M4: descending, (r1, w0).
  - M5: descending, (r0).
- Per-address sequences:
  - M1-M4: RD, CHK, WR (3 cycles).
  - M0: WR (1 cycle).
  - M5: RD, CHK (2 cycles).
- Total test length T = N + 12N + 2N = 15N cycles. For N=256, T=3840.
- States and transitions:
  - IDLE → M0 first WR when start=1. busy goes high on the cycle following the start edge.
  - Element transition: after the last address of an element, move to the next element's first address. Ascending elements start at 0; descending elements start at N-1. No idle cycles are inserted between elements.
  - After M5 at address 0: DONE. busy=0, done=1, fail=0, S_n=1.
  - Mismatch in CHK: the next cycle is DONE with fail=1 and fail_elem/fail_addr/fail_data latched. The test stops at the first failure; no further RAM cycles are issued.
  - DONE → M0 when start=1. done, fail and the fail_* outputs clear on that cycle.
- busy is high for exactly T cycles on a clean run. done rises on the cycle after busy falls.
- start while busy is ignored; the test is not restarted.
- Address counter: ADDR_WIDTH bits. Element end is detected at N-1 (ascending) or 0 (descending), never by wrap.
- S_n=1 in every cycle except WR/RD. A and D hold their last values when not in use.

Test Plan:
- Fault-free TTL74x201 (8-bit): pulse start → busy high 3840 cycles; then done=1, fail=0.
- Stuck-at-0 at cell 0x37 (bench forces stored bit to 0) → done=1, fail=1, fail_elem=2, fail_addr=0x37, fail_data=0.
- Stuck-at-1 at cell 0x37 → fail=1, fail_elem=1, fail_addr=0x37, fail_data=1.
- Address-decoder fault (bench ties RAM A[7] to 0) → fail=1, fail_elem=1, fail_addr=0x80, fail_data=1.
- ADDR_WIDTH=4, fault-free → busy high 240 cycles, fail=0. Pulse start again from DONE → second clean run of 240 cycles.
- Assert rst_n=0 at cycle 1000 of a run → outputs immediately take reset values (S_n=1, busy=0). A start pulse during busy on another run leaves the cycle count at 3840.
